// File: rtl/pipeline_pkg.sv
// Shared constants and types for the multi-cycle RV32I pipeline:
// opcode/funct3 encodings, FSM state type, ALU operation type and decoder.
package pipeline_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_EXEC,
    ST_LOAD
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_t;

  // alt is instr[30]; it selects SUB only for register-register ops,
  // since an ADDI immediate may legitimately have that bit set.
  function automatic alu_op_t alu_decode(logic [2:0] f3, logic alt, logic is_op);
    alu_op_t op;
    op = ALU_ADD;
    case (f3)
      F3_ADD:  op = (is_op && alt) ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/pipeline_alu.sv
// Combinational RV32I ALU with branch-compare flags on the same operands.
module pipeline_alu
  import pipeline_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] result,
  output logic        eq,
  output logic        lt,
  output logic        ltu
);

  assign eq  = (a == b);
  assign lt  = ($signed(a) < $signed(b));
  assign ltu = (a < b);

  // Operation select; shifts use only the low five bits of b.
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SLT:  result = {31'd0, lt};
      ALU_SLTU: result = {31'd0, ltu};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $signed(a) >>> b[4:0];
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/pipeline.sv
// Multi-cycle RV32I core on a single shared synchronous memory port.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_FETCH | drive PC on mem_addr; instruction arrives next cycle
//   ST_EXEC  | decode mem_rdata, execute; loads issue address, stores write
//   ST_LOAD  | load data on mem_rdata: extract lane, extend, write rd
module pipeline
  import pipeline_pkg::*;
#(
  parameter logic [31:0] START_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        mem_wren,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] regs [32];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, pc_plus4, addr_sum;

  logic [31:0] alu_b, alu_result;
  alu_op_t     alu_op;
  logic        alu_eq, alu_lt, alu_ltu;

  logic [4:0]  ld_rd_q;
  logic [2:0]  ld_f3_q;
  logic [1:0]  ld_lo_q;
  logic [31:0] load_val;

  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] addr_c, wdata_c;
  logic        wren_c, taken, load_ok;
  logic [3:0]  wmask_c;

  // Instruction fields are decoded straight off the memory read port.
  assign opcode = mem_rdata[6:0];
  assign rd     = mem_rdata[11:7];
  assign funct3 = mem_rdata[14:12];
  assign rs1    = mem_rdata[19:15];
  assign rs2    = mem_rdata[24:20];
  assign imm_i  = {{20{mem_rdata[31]}}, mem_rdata[31:20]};
  assign imm_s  = {{20{mem_rdata[31]}}, mem_rdata[31:25], mem_rdata[11:7]};
  assign imm_b  = {{19{mem_rdata[31]}}, mem_rdata[31], mem_rdata[7],
                   mem_rdata[30:25], mem_rdata[11:8], 1'b0};
  assign imm_u  = {mem_rdata[31:12], 12'd0};
  assign imm_j  = {{11{mem_rdata[31]}}, mem_rdata[31], mem_rdata[19:12],
                   mem_rdata[20], mem_rdata[30:21], 1'b0};

  assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
  assign pc_plus4 = pc_q + 32'd4;
  assign addr_sum = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
  assign load_ok  = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                    (funct3 == F3_LBU) || (funct3 == F3_LHU);

  assign alu_b  = ((opcode == OPC_OP) || (opcode == OPC_BRANCH)) ? rs2_val : imm_i;
  assign alu_op = alu_decode(funct3, mem_rdata[30], opcode == OPC_OP);

  pipeline_alu u_alu (
    .a      (rs1_val),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result),
    .eq     (alu_eq),
    .lt     (alu_lt),
    .ltu    (alu_ltu)
  );

  // Branch condition from the ALU compare flags; reserved funct3 never branches.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = alu_eq;
      F3_BNE:  taken = !alu_eq;
      F3_BLT:  taken = alu_lt;
      F3_BGE:  taken = !alu_lt;
      F3_BLTU: taken = alu_ltu;
      F3_BGEU: taken = !alu_ltu;
      default: taken = 1'b0;
    endcase
  end

  // Lane extraction for the load completing this cycle; bit 0 is ignored for halfwords.
  always_comb begin
    logic [7:0]  lb;
    logic [15:0] lh;
    case (ld_lo_q)
      2'd0:    lb = mem_rdata[7:0];
      2'd1:    lb = mem_rdata[15:8];
      2'd2:    lb = mem_rdata[23:16];
      default: lb = mem_rdata[31:24];
    endcase
    lh = ld_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ld_f3_q)
      F3_LB:   load_val = {{24{lb[7]}}, lb};
      F3_LH:   load_val = {{16{lh[15]}}, lh};
      F3_LBU:  load_val = {24'd0, lb};
      F3_LHU:  load_val = {16'd0, lh};
      default: load_val = mem_rdata;
    endcase
  end

  // Next-state, PC, register write and memory-port control.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rf_we   = 1'b0;
    rf_wa   = rd;
    rf_wd   = 32'd0;
    addr_c  = pc_q;
    wren_c  = 1'b0;
    wmask_c = 4'd0;
    wdata_c = 32'd0;
    case (state_q)
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_plus4;
        case (opcode)
          OPC_LUI:   begin rf_we = 1'b1; rf_wd = imm_u; end
          OPC_AUIPC: begin rf_we = 1'b1; rf_wd = pc_q + imm_u; end
          OPC_JAL: begin
            rf_we = 1'b1;
            rf_wd = pc_plus4;
            pc_d  = pc_q + imm_j;
          end
          OPC_JALR: begin
            rf_we = 1'b1;
            rf_wd = pc_plus4;
            pc_d  = (rs1_val + imm_i) & ~32'd1;
          end
          OPC_BRANCH: pc_d = taken ? (pc_q + imm_b) : pc_plus4;
          OPC_LOAD: begin
            if (load_ok) begin
              addr_c  = addr_sum;
              state_d = ST_LOAD;
              pc_d    = pc_q;
            end
          end
          OPC_STORE: begin
            addr_c = addr_sum;
            case (funct3)
              F3_SB: begin
                wren_c  = 1'b1;
                wmask_c = 4'b0001 << addr_sum[1:0];
                wdata_c = {4{rs2_val[7:0]}};
              end
              F3_SH: begin
                wren_c  = 1'b1;
                wmask_c = addr_sum[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{rs2_val[15:0]}};
              end
              F3_SW: begin
                wren_c  = 1'b1;
                wmask_c = 4'b1111;
                wdata_c = rs2_val;
              end
              default: ;
            endcase
          end
          OPC_OPIMM, OPC_OP: begin rf_we = 1'b1; rf_wd = alu_result; end
          default: ;
        endcase
      end
      ST_LOAD: begin
        rf_we   = 1'b1;
        rf_wa   = ld_rd_q;
        rf_wd   = load_val;
        pc_d    = pc_plus4;
        state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Reset overrides the port so an aborted store never reaches memory.
  assign mem_wren  = rstn & wren_c;
  assign mem_wmask = rstn ? wmask_c : 4'd0;
  assign mem_wdata = wdata_c;
  assign mem_addr  = rstn ? addr_c : START_PC;

  // State and PC registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_FETCH;
      pc_q    <= START_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Load bookkeeping captured in EXEC; the instruction is gone by the LOAD cycle.
  always_ff @(posedge clk) begin
    if (state_q == ST_EXEC) begin
      ld_rd_q <= rd;
      ld_f3_q <= funct3;
      ld_lo_q <= addr_sum[1:0];
    end
  end

  // Register file write; x0 is never written and contents are not reset.
  always_ff @(posedge clk) begin
    if (rstn && rf_we && (rf_wa != 5'd0)) begin
      regs[rf_wa] <= rf_wd;
    end
  end

endmodule

// File: tb/tb_pipeline.sv
// Directed bench for pipeline: small programs in a synchronous memory model,
// bus trace and store capture compared against hand-computed values.
module tb_pipeline;

  localparam logic [31:0] SPC = 32'h0002_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        mem_wren;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata, mem_addr;
  logic [31:0] mem_rdata = 32'd0;

  logic [31:0] mem [1024];
  logic        ld_we = 1'b0;
  logic [9:0]  ld_idx = 10'd0;
  logic [31:0] ld_val = 32'd0;

  int total = 0;
  int passed = 0;

  logic [31:0] tr_addr[$];
  logic [31:0] tr_wren[$];
  logic [31:0] st_addr[$];
  logic [31:0] st_mask[$];
  logic [31:0] st_data[$];

  always #5 clk = ~clk;

  pipeline #(.START_PC(SPC)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .mem_wren  (mem_wren),
    .mem_wmask (mem_wmask),
    .mem_wdata (mem_wdata),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  // Synchronous memory: byte-masked write and registered read on the same edge.
  always @(posedge clk) begin : mem_model
    logic [31:0] w;
    w = mem[mem_addr[11:2]];
    for (int i = 0; i < 4; i++)
      if (mem_wmask[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
    if (ld_we) mem[ld_idx] <= ld_val;
    else if (mem_wren) mem[mem_addr[11:2]] <= w;
    mem_rdata <= mem[mem_addr[11:2]];
  end

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(logic [19:0] imm, logic [4:0] rd, logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic put(logic [31:0] addr, logic [31:0] val);
    ld_we  = 1'b1;
    ld_idx = addr[11:2];
    ld_val = val;
    @(negedge clk);
    ld_we  = 1'b0;
  endtask

  task automatic begin_prog();
    rstn = 1'b0;
    @(negedge clk);
  endtask

  // Checks the reset-time port values, releases reset, records n cycles.
  task automatic release_and_run(string name, int n);
    #1;
    chk({name, "_rst_addr"}, mem_addr, SPC);
    chk({name, "_rst_wren"}, {31'd0, mem_wren}, 32'd0);
    chk({name, "_rst_mask"}, {28'd0, mem_wmask}, 32'd0);
    rstn = 1'b1;
    tr_addr.delete(); tr_wren.delete();
    st_addr.delete(); st_mask.delete(); st_data.delete();
    for (int i = 0; i < n; i++) begin
      #1;
      tr_addr.push_back(mem_addr);
      tr_wren.push_back({31'd0, mem_wren});
      if (mem_wren) begin
        st_addr.push_back(mem_addr);
        st_mask.push_back({28'd0, mem_wmask});
        st_data.push_back(mem_wdata);
      end
      @(negedge clk);
    end
  endtask

  initial begin : stim
    logic [31:0] alu_exp [12];
    alu_exp = '{32'hFFFF_FFFC, 32'h0000_000F, 32'h0000_0001, 32'h0000_0000,
                32'h0000_0008, 32'hFFFC_0000, 32'h1234_5000, 32'h0002_1020,
                32'hEDCB_AFFF, 32'hFFFF_FFFF, 32'h0000_0024, 32'h0000_0080};

    // Reset vector and NOP sequencing.
    begin_prog();
    for (int i = 0; i < 1024; i++) put(32'(i * 4), NOP);
    release_and_run("nop", 6);
    chk("nop_fetch0", tr_addr[0], SPC);
    chk("nop_wren0", tr_wren[0], 32'd0);
    chk("nop_wren1", tr_wren[1], 32'd0);
    chk("nop_fetch1", tr_addr[2], 32'h0002_0004);
    chk("nop_fetch2", tr_addr[4], 32'h0002_0008);

    // addi / addi / sw.
    begin_prog();
    put(SPC + 0,  enc_i(12'd5,   5'd0, 3'd0, 5'd1, 7'h13));
    put(SPC + 4,  enc_i(12'hFFD, 5'd1, 3'd0, 5'd2, 7'h13));
    put(SPC + 8,  enc_s(12'h100, 5'd2, 5'd0, 3'd2));
    put(SPC + 12, 32'h0000_006F);
    release_and_run("sw", 14);
    chk("sw_count", st_addr.size(), 32'd1);
    chk("sw_cycle", tr_wren[5], 32'd1);
    chk("sw_addr", st_addr[0], 32'h0000_0100);
    chk("sw_mask", st_mask[0], 32'hF);
    chk("sw_data", st_data[0], 32'h0000_0002);

    // Byte/halfword stores, lane replication, misaligned halfword and word.
    begin_prog();
    put(SPC + 0,  enc_i(12'h0A5, 5'd0, 3'd0, 5'd1, 7'h13));
    put(SPC + 4,  enc_s(12'h103, 5'd1, 5'd0, 3'd0));
    put(SPC + 8,  enc_s(12'h102, 5'd1, 5'd0, 3'd1));
    put(SPC + 12, enc_s(12'h101, 5'd1, 5'd0, 3'd1));
    put(SPC + 16, enc_s(12'h107, 5'd1, 5'd0, 3'd2));
    put(SPC + 20, 32'h0000_006F);
    release_and_run("st", 16);
    chk("st_count", st_addr.size(), 32'd4);
    chk("sb_addr", st_addr[0], 32'h0000_0103);
    chk("sb_mask", st_mask[0], 32'b1000);
    chk("sb_data", st_data[0], 32'hA5A5_A5A5);
    chk("sh_mask", st_mask[1], 32'b1100);
    chk("sh_data", st_data[1], 32'h00A5_00A5);
    chk("sh_mis_mask", st_mask[2], 32'b0011);
    chk("sw_mis_addr", st_addr[3], 32'h0000_0107);
    chk("sw_mis_mask", st_mask[3], 32'b1111);
    chk("sw_mis_data", st_data[3], 32'h0000_00A5);

    // Loads with lane selection and extension, plus x0 write discard.
    begin_prog();
    put(32'h180, 32'h80FF_7F01);
    put(SPC + 8'h00, enc_i(12'h181, 5'd0, 3'd0, 5'd1, 7'h03));
    put(SPC + 8'h04, enc_s(12'h300, 5'd1, 5'd0, 3'd2));
    put(SPC + 8'h08, enc_i(12'h183, 5'd0, 3'd0, 5'd2, 7'h03));
    put(SPC + 8'h0C, enc_s(12'h304, 5'd2, 5'd0, 3'd2));
    put(SPC + 8'h10, enc_i(12'h183, 5'd0, 3'd4, 5'd3, 7'h03));
    put(SPC + 8'h14, enc_s(12'h308, 5'd3, 5'd0, 3'd2));
    put(SPC + 8'h18, enc_i(12'h182, 5'd0, 3'd1, 5'd4, 7'h03));
    put(SPC + 8'h1C, enc_s(12'h30C, 5'd4, 5'd0, 3'd2));
    put(SPC + 8'h20, enc_i(12'h183, 5'd0, 3'd5, 5'd5, 7'h03));
    put(SPC + 8'h24, enc_s(12'h310, 5'd5, 5'd0, 3'd2));
    put(SPC + 8'h28, enc_i(12'h182, 5'd0, 3'd2, 5'd6, 7'h03));
    put(SPC + 8'h2C, enc_s(12'h314, 5'd6, 5'd0, 3'd2));
    put(SPC + 8'h30, enc_i(12'd5,   5'd0, 3'd0, 5'd0, 7'h13));
    put(SPC + 8'h34, enc_s(12'h318, 5'd0, 5'd0, 3'd2));
    put(SPC + 8'h38, 32'h0000_006F);
    release_and_run("ld", 44);
    chk("ld_addr", tr_addr[1], 32'h0000_0181);
    chk("ld_3cyc", tr_addr[3], 32'h0002_0004);
    chk("ld_count", st_addr.size(), 32'd7);
    chk("lb_off1", st_data[0], 32'h0000_007F);
    chk("lb_off3", st_data[1], 32'hFFFF_FF80);
    chk("lbu_off3", st_data[2], 32'h0000_0080);
    chk("lh_off2", st_data[3], 32'hFFFF_80FF);
    chk("lhu_off3", st_data[4], 32'h0000_80FF);
    chk("lw_off2", st_data[5], 32'h80FF_7F01);
    chk("x0_zero", st_data[6], 32'h0000_0000);

    // ALU: shifts, compares, sub, lui/auipc, xori, shift amount masking.
    begin_prog();
    put(SPC + 8'h00, enc_i(12'hFF8, 5'd1, 3'd0, 5'd1, 7'h13) & 32'hFFF0_7FFF);
    put(SPC + 8'h04, enc_i(12'h401, 5'd1, 3'd5, 5'd2, 7'h13));
    put(SPC + 8'h08, enc_i(12'd28,  5'd1, 3'd5, 5'd3, 7'h13));
    put(SPC + 8'h0C, enc_r(7'h00, 5'd0, 5'd1, 3'd2, 5'd4));
    put(SPC + 8'h10, enc_r(7'h00, 5'd0, 5'd1, 3'd3, 5'd5));
    put(SPC + 8'h14, enc_r(7'h20, 5'd1, 5'd0, 3'd0, 5'd6));
    put(SPC + 8'h18, enc_r(7'h00, 5'd3, 5'd1, 3'd1, 5'd7));
    put(SPC + 8'h1C, enc_u(20'h12345, 5'd8, 7'h37));
    put(SPC + 8'h20, enc_u(20'h00001, 5'd9, 7'h17));
    put(SPC + 8'h24, enc_i(12'hFFF, 5'd8, 3'd4, 5'd10, 7'h13));
    put(SPC + 8'h28, enc_r(7'h20, 5'd3, 5'd1, 3'd5, 5'd11));
    put(SPC + 8'h2C, enc_i(12'd36,  5'd0, 3'd0, 5'd12, 7'h13));
    put(SPC + 8'h30, enc_r(7'h00, 5'd12, 5'd6, 3'd1, 5'd13));
    for (int r = 2; r <= 13; r++)
      put(SPC + 32'h34 + 32'(4 * (r - 2)), enc_s(12'(12'h300 + 4 * (r - 2)), 5'(r), 5'd0, 3'd2));
    put(SPC + 8'h64, 32'h0000_006F);
    release_and_run("alu", 60);
    chk("alu_count", st_addr.size(), 32'd12);
    for (int k = 0; k < 12; k++)
      chk($sformatf("alu_x%0d", k + 2), st_data[k], alu_exp[k]);

    // jal x0,0 spins on one PC with no stores.
    begin_prog();
    put(SPC + 0, NOP);
    put(SPC + 4, 32'h0000_006F);
    release_and_run("jal0", 12);
    for (int k = 1; k <= 5; k++)
      chk($sformatf("jal0_fetch%0d", k), tr_addr[2 * k], 32'h0002_0004);
    chk("jal0_nostore", st_addr.size(), 32'd0);

    // Branches taken / not taken, jal link, jalr odd target, jalr rd==rs1.
    begin_prog();
    put(SPC + 8'h00, enc_i(12'd7,   5'd0, 3'd0, 5'd1, 7'h13));
    put(SPC + 8'h04, enc_i(12'd7,   5'd0, 3'd0, 5'd2, 7'h13));
    put(SPC + 8'h08, enc_i(12'h201, 5'd0, 3'd0, 5'd4, 7'h13));
    put(SPC + 8'h0C, enc_b(13'd12, 5'd2, 5'd1, 3'd0));
    put(SPC + 8'h10, NOP);
    put(SPC + 8'h14, NOP);
    put(SPC + 8'h18, enc_b(13'd8, 5'd0, 5'd1, 3'd0));
    put(SPC + 8'h1C, enc_j(21'd8, 5'd5));
    put(SPC + 8'h20, NOP);
    put(SPC + 8'h24, enc_i(12'd0, 5'd4, 3'd0, 5'd3, 7'h67));
    put(32'h200, enc_s(12'h104, 5'd3, 5'd0, 3'd2));
    put(32'h204, enc_s(12'h108, 5'd5, 5'd0, 3'd2));
    put(32'h208, enc_i(12'h214, 5'd0, 3'd0, 5'd6, 7'h13));
    put(32'h20C, enc_i(12'd0, 5'd6, 3'd0, 5'd6, 7'h67));
    put(32'h210, NOP);
    put(32'h214, enc_s(12'h10C, 5'd6, 5'd0, 3'd2));
    put(32'h218, 32'h0000_006F);
    release_and_run("br", 30);
    chk("br_fetch_beq", tr_addr[6], 32'h0002_000C);
    chk("br_taken", tr_addr[8], 32'h0002_0018);
    chk("br_not_taken", tr_addr[10], 32'h0002_001C);
    chk("jal_target", tr_addr[12], 32'h0002_0024);
    chk("jalr_odd", tr_addr[14], 32'h0000_0200);
    chk("jalr_same_rd", tr_addr[22], 32'h0000_0214);
    chk("br_count", st_addr.size(), 32'd3);
    chk("jalr_link", st_data[0], 32'h0002_0028);
    chk("jal_link", st_data[1], 32'h0002_0020);
    chk("jalr_rd_rs1", st_data[2], 32'h0000_0210);

    // Reset in the store's EXEC cycle must suppress the write.
    begin_prog();
    put(32'h100, 32'hDEAD_BEEF);
    put(SPC + 0, enc_s(12'h100, 5'd0, 5'd0, 3'd2));
    put(SPC + 4, 32'h0000_006F);
    #1;
    chk("ab_rst_addr", mem_addr, SPC);
    rstn = 1'b1;
    #1;
    chk("ab_fetch_wren", {31'd0, mem_wren}, 32'd0);
    @(negedge clk);
    #1;
    chk("ab_pre_wren", {31'd0, mem_wren}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("ab_wren", {31'd0, mem_wren}, 32'd0);
    chk("ab_mask", {28'd0, mem_wmask}, 32'd0);
    chk("ab_addr", mem_addr, SPC);
    @(negedge clk);
    @(negedge clk);
    chk("ab_mem_kept", mem[64], 32'hDEAD_BEEF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipeline.md
PIPELINE -- requirements
Module: pipeline

Interface
REQ-001 SHALL have parameter START_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rstn  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port mem_wren  output  1  store strobe; memory write occurs at the clock edge ending the cycle.
REQ-005 SHALL have port mem_wmask  output  4  byte-lane enables, bit i = byte i of mem_wdata.
REQ-006 SHALL have port mem_wdata  output  32  store data, already shifted to its byte lane.
REQ-007 SHALL have port mem_addr  output  32  full byte address, shared by fetch and data access.
REQ-008 SHALL have port mem_rdata  input  32  read data, valid exactly one cycle after its mem_addr (synchronous memory).

Function
REQ-009 SHALL execute RV32I integer instructions: LUI, AUIPC, JAL, JALR, BRANCH (6), LOAD (LB/LH/LW/LBU/LHU), STORE (SB/SH/SW), OP-IMM, OP.
REQ-010 SHALL treat FENCE, SYSTEM and every unrecognised opcode as NOP (PC+4, no register or memory write, no trap).
REQ-011 SHALL use a single shared memory port, controlled by an FSM with states FETCH, EXEC, LOAD.
REQ-012 FETCH: mem_addr=PC, mem_wren=0; next state EXEC.
REQ-013 EXEC: instruction = mem_rdata; non-memory instructions write rd, update PC and return to FETCH (2 cycles per instruction).
REQ-014 EXEC, load: mem_addr = rs1+imm, mem_wren=0; next state LOAD.
REQ-015 LOAD: extract and sign- or zero-extend the lane selected by addr[1:0], write rd, PC+=4; next state FETCH (3 cycles per load).
REQ-016 EXEC, store: mem_addr = rs1+imm, mem_wren=1, mask and data as REQ-017; PC+=4; next state FETCH (2 cycles per store).
REQ-017 Store masks: SB 0001<<addr[1:0], data byte replicated to all four lanes; SH 0011<<(addr[1]*2), data halfword replicated to both halves; SW 1111, addr[1:0] ignored.
REQ-018 Misaligned access SHALL be resolved by ignoring addr[0] for halfwords and addr[1:0] for words, with no exception.
REQ-019 mem_wren and mem_wmask SHALL be 0 in every state except EXEC-store.
REQ-020 x0 SHALL read 0 always; writes to x0 are discarded.
REQ-021 JALR target SHALL be (rs1+imm) with bit 0 cleared; rd receives PC+4, computed before rs1 is overwritten when rd==rs1.
REQ-022 Shift amount SHALL use bits [4:0]; SRA/SRAI arithmetic; SLT signed, SLTU unsigned; all arithmetic wraps modulo 2^32.
REQ-023 mem_addr SHALL be combinational from state, PC, mem_rdata and the register file, so memory may register it.

Reset
REQ-024 While rstn=0 at a clock edge: PC <= START_PC, state <= FETCH.
REQ-025 During and immediately after reset: mem_wren=0, mem_wmask=0, mem_addr=START_PC.
REQ-026 Register file contents SHALL NOT be reset (x1..x31 undefined after reset).
REQ-027 Reset asserted mid-instruction SHALL abort it with no register write and no memory write in the reset cycle.

Structure
REQ-028 Shared package pipeline_pkg SHALL hold opcode/funct3 constants, the FSM state type and the ALU operation type.
REQ-029 One sub-module pipeline_alu (combinational, operands a/b, op, result, branch-compare outputs) SHALL be used; the register file and FSM SHALL stay in pipeline.

Verification
REQ-030 Reset with START_PC=0x0002_0000, release rstn -> mem_addr=0x0002_0000 and mem_wren=0 in the first cycle, then 0x0002_0004 two cycles later if NOP.
REQ-031 addi x1,x0,5; addi x2,x1,-3; sw x2,0x100(x0) -> one cycle with mem_wren=1, mem_addr=0x100, mem_wmask=1111, mem_wdata=0x00000002.
REQ-032 x1=0xA5, sb x1,0x103(x0) -> mem_addr=0x103, mem_wmask=1000, mem_wdata=0xA5A5A5A5; sh to 0x102 -> mask 1100.
REQ-033 Memory word 0x80FF7F01: lb offset 1 -> 0x0000007F; lb offset 3 -> 0xFFFFFF80; lbu offset 3 -> 0x00000080; lh offset 2 -> 0xFFFF80FF.
REQ-034 Fetch 0x0000006F (jal x0,0) -> mem_addr repeats the same PC every 2 cycles, mem_wren never asserts.
REQ-035 beq taken/not taken, and jalr with odd target 0x201 -> next fetch at branch target, PC+4, and 0x200 respectively; rd=PC+4.
